// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: functional-unit writeback requests and common-data-bus broadcast slots.
// The FU/consumer side takes the master modport; the arbiter takes the slave modport.
interface cdb_arbiter_if #(
    parameter int NUM_FU     = 4,
    parameter int CDB_WIDTH  = 2,
    parameter int ROB_ID_W   = 5,
    parameter int PRF_IDX_W  = 6,
    parameter int ARCH_IDX_W = 5,
    parameter int DATA_W     = 32
) ();
    logic [NUM_FU-1:0]              fu_valid;
    logic [NUM_FU-1:0]              fu_ready;
    logic [NUM_FU*ROB_ID_W-1:0]     fu_rob_id;
    logic [NUM_FU*PRF_IDX_W-1:0]    fu_rd_phy;
    logic [NUM_FU*ARCH_IDX_W-1:0]   fu_rd_arch;
    logic [NUM_FU*DATA_W-1:0]       fu_rd_value;

    logic [CDB_WIDTH-1:0]            cdb_valid;
    logic [CDB_WIDTH*ROB_ID_W-1:0]   cdb_rob_id;
    logic [CDB_WIDTH*PRF_IDX_W-1:0]  cdb_rd_phy;
    logic [CDB_WIDTH*ARCH_IDX_W-1:0] cdb_rd_arch;
    logic [CDB_WIDTH*DATA_W-1:0]     cdb_rd_value;

    modport master (
        output fu_valid, fu_rob_id, fu_rd_phy, fu_rd_arch, fu_rd_value,
        input  fu_ready,
        input  cdb_valid, cdb_rob_id, cdb_rd_phy, cdb_rd_arch, cdb_rd_value
    );

    modport slave (
        input  fu_valid, fu_rob_id, fu_rd_phy, fu_rd_arch, fu_rd_value,
        output fu_ready,
        output cdb_valid, cdb_rob_id, cdb_rd_phy, cdb_rd_arch, cdb_rd_value
    );
endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbitration of NUM_FU writeback requests onto CDB_WIDTH
// registered broadcast slots (one cycle from grant to CDB).
// Optional macro CDB_ARB_STATS_EN adds per-FU saturating grant/stall counters.
module cdb_arbiter #(
    parameter int NUM_FU     = 4,
    parameter int CDB_WIDTH  = 2,
    parameter int ROB_ID_W   = 5,
    parameter int PRF_IDX_W  = 6,
    parameter int ARCH_IDX_W = 5,
    parameter int DATA_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
`ifdef CDB_ARB_STATS_EN
    output logic [NUM_FU*32-1:0] stat_grant_cnt,
    output logic [NUM_FU*32-1:0] stat_stall_cnt,
`endif
    cdb_arbiter_if.slave         bus
);
    localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
    localparam int SUM_W = PTR_W + 1;
    localparam int CNT_W = $clog2(CDB_WIDTH + 1);

    logic [PTR_W-1:0]                rr_ptr;
    logic [PTR_W-1:0]                next_ptr_s;
    logic                            any_grant_s;
    logic [NUM_FU-1:0]               grant_s;
    logic [CDB_WIDTH-1:0]            slot_valid_s;
    logic [PTR_W-1:0]                slot_sel_s [CDB_WIDTH];

    logic [CDB_WIDTH-1:0]            cdb_valid_r;
    logic [CDB_WIDTH*ROB_ID_W-1:0]   cdb_rob_id_r;
    logic [CDB_WIDTH*PRF_IDX_W-1:0]  cdb_rd_phy_r;
    logic [CDB_WIDTH*ARCH_IDX_W-1:0] cdb_rd_arch_r;
    logic [CDB_WIDTH*DATA_W-1:0]     cdb_rd_value_r;

    // Scan FUs from rr_ptr with wrap, granting the first CDB_WIDTH valid requesters in order.
    always_comb begin
        logic [CNT_W-1:0] cnt;
        logic [SUM_W-1:0] idx;
        logic [PTR_W-1:0] last;
        grant_s      = '0;
        slot_valid_s = '0;
        any_grant_s  = 1'b0;
        cnt          = '0;
        idx          = '0;
        last         = '0;
        for (int k = 0; k < CDB_WIDTH; k++) begin
            slot_sel_s[k] = '0;
        end
        for (int off = 0; off < NUM_FU; off++) begin
            idx = SUM_W'(rr_ptr) + SUM_W'(off);
            if (idx >= SUM_W'(NUM_FU)) begin
                idx = idx - SUM_W'(NUM_FU);
            end else begin
                idx = idx;
            end
            if (!rst && !flush && bus.fu_valid[idx] && (cnt < CNT_W'(CDB_WIDTH))) begin
                grant_s[idx]      = 1'b1;
                slot_valid_s[cnt] = 1'b1;
                slot_sel_s[cnt]   = PTR_W'(idx);
                last              = PTR_W'(idx);
                any_grant_s       = 1'b1;
                cnt               = cnt + CNT_W'(1);
            end else begin
                cnt = cnt;
            end
        end
        if (last == PTR_W'(NUM_FU - 1)) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = last + PTR_W'(1);
        end
    end

    assign bus.fu_ready     = grant_s;
    assign bus.cdb_valid    = cdb_valid_r;
    assign bus.cdb_rob_id   = cdb_rob_id_r;
    assign bus.cdb_rd_phy   = cdb_rd_phy_r;
    assign bus.cdb_rd_arch  = cdb_rd_arch_r;
    assign bus.cdb_rd_value = cdb_rd_value_r;

    // Register the granted payloads into their slots and advance the round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            cdb_valid_r    <= '0;
            cdb_rob_id_r   <= '0;
            cdb_rd_phy_r   <= '0;
            cdb_rd_arch_r  <= '0;
            cdb_rd_value_r <= '0;
            rr_ptr         <= '0;
        end else begin
            cdb_valid_r <= slot_valid_s;
            for (int k = 0; k < CDB_WIDTH; k++) begin
                if (slot_valid_s[k]) begin
                    cdb_rob_id_r[k*ROB_ID_W +: ROB_ID_W] <=
                        bus.fu_rob_id[int'(slot_sel_s[k])*ROB_ID_W +: ROB_ID_W];
                    cdb_rd_phy_r[k*PRF_IDX_W +: PRF_IDX_W] <=
                        bus.fu_rd_phy[int'(slot_sel_s[k])*PRF_IDX_W +: PRF_IDX_W];
                    cdb_rd_arch_r[k*ARCH_IDX_W +: ARCH_IDX_W] <=
                        bus.fu_rd_arch[int'(slot_sel_s[k])*ARCH_IDX_W +: ARCH_IDX_W];
                    cdb_rd_value_r[k*DATA_W +: DATA_W] <=
                        bus.fu_rd_value[int'(slot_sel_s[k])*DATA_W +: DATA_W];
                end
            end
            if (any_grant_s) begin
                rr_ptr <= next_ptr_s;
            end
        end
    end

`ifdef CDB_ARB_STATS_EN
    logic [31:0] grant_cnt_r [NUM_FU];
    logic [31:0] stall_cnt_r [NUM_FU];

    // Per-FU saturating counters of grants and of valid-but-not-granted cycles; flush does not clear them.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_FU; i++) begin
                grant_cnt_r[i] <= 32'd0;
                stall_cnt_r[i] <= 32'd0;
            end
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (grant_s[i] && (grant_cnt_r[i] != 32'hFFFF_FFFF)) begin
                    grant_cnt_r[i] <= grant_cnt_r[i] + 32'd1;
                end
                if (bus.fu_valid[i] && !grant_s[i] && (stall_cnt_r[i] != 32'hFFFF_FFFF)) begin
                    stall_cnt_r[i] <= stall_cnt_r[i] + 32'd1;
                end
            end
        end
    end

    // Flatten the counter arrays onto the packed stat ports.
    always_comb begin
        stat_grant_cnt = '0;
        stat_stall_cnt = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            stat_grant_cnt[i*32 +: 32] = grant_cnt_r[i];
            stat_stall_cnt[i*32 +: 32] = stall_cnt_r[i];
        end
    end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed checks of cdb_arbiter (NUM_FU=4, CDB_WIDTH=2).
module tb_cdb_arbiter;
    logic clk;
    logic rst;
    logic flush;
    int   total;
    int   bad;

    cdb_arbiter_if #(.NUM_FU(4), .CDB_WIDTH(2), .ROB_ID_W(5), .PRF_IDX_W(6),
                     .ARCH_IDX_W(5), .DATA_W(32)) bus ();

`ifdef CDB_ARB_STATS_EN
    logic [127:0] stat_grant_cnt;
    logic [127:0] stat_stall_cnt;
`endif

    cdb_arbiter #(.NUM_FU(4), .CDB_WIDTH(2), .ROB_ID_W(5), .PRF_IDX_W(6),
                  .ARCH_IDX_W(5), .DATA_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
`ifdef CDB_ARB_STATS_EN
        .stat_grant_cnt (stat_grant_cnt),
        .stat_stall_cnt (stat_stall_cnt),
`endif
        .bus            (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fu(input int i, input logic [4:0] rob, input logic [5:0] phy,
                          input logic [4:0] arch, input logic [31:0] val);
        bus.fu_rob_id[i*5 +: 5]     = rob;
        bus.fu_rd_phy[i*6 +: 6]     = phy;
        bus.fu_rd_arch[i*5 +: 5]    = arch;
        bus.fu_rd_value[i*32 +: 32] = val;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        flush = 1'b0;
        bus.fu_valid    = 4'b1111;
        bus.fu_rob_id   = '0;
        bus.fu_rd_phy   = '0;
        bus.fu_rd_arch  = '0;
        bus.fu_rd_value = '0;

        // Reset state
        #1;
        check("rst_ready", 64'(bus.fu_ready), 64'h0);
        step();
        step();
        check("rst_cdb_valid", 64'(bus.cdb_valid), 64'h0);
        check("rst_rr_ptr", 64'(dut.rr_ptr), 64'h0);
        check("rst_payload", 64'(bus.cdb_rob_id), 64'h0);
        rst = 1'b0;
        bus.fu_valid = 4'b0000;
        #1;
        check("idle_ready", 64'(bus.fu_ready), 64'h0);
        step();
        check("idle_cdb_valid", 64'(bus.cdb_valid), 64'h0);

        // Single request from FU0
        set_fu(0, 5'd3, 6'd1, 5'd1, 32'h3);
        bus.fu_valid = 4'b0001;
        #1;
        check("single_ready", 64'(bus.fu_ready), 64'h1);
        step();
        bus.fu_valid = 4'b0000;
        check("single_cdb_valid", 64'(bus.cdb_valid), 64'h1);
        check("single_rob", 64'(bus.cdb_rob_id[4:0]), 64'd3);
        check("single_phy", 64'(bus.cdb_rd_phy[5:0]), 64'd1);
        check("single_arch", 64'(bus.cdb_rd_arch[4:0]), 64'd1);
        check("single_value", 64'(bus.cdb_rd_value[31:0]), 64'h3);
        check("single_rr", 64'(dut.rr_ptr), 64'd1);

        // Move pointer to 0 via lone FU3 grant
        set_fu(3, 5'd13, 6'd23, 5'd7, 32'hA000_0003);
        bus.fu_valid = 4'b1000;
        step();
        check("fu3_rr", 64'(dut.rr_ptr), 64'd0);
        check("fu3_slot0_rob", 64'(bus.cdb_rob_id[4:0]), 64'd13);

        // All four valid continuously from rr_ptr=0
        set_fu(0, 5'd10, 6'd20, 5'd4, 32'hA000_0000);
        set_fu(1, 5'd11, 6'd21, 5'd5, 32'hA000_0001);
        set_fu(2, 5'd12, 6'd22, 5'd6, 32'hA000_0002);
        bus.fu_valid = 4'b1111;
        #1;
        check("all_c0_ready", 64'(bus.fu_ready), 64'b0011);
        step();
        check("all_c0_valid", 64'(bus.cdb_valid), 64'b11);
        check("all_c0_slot0", 64'(bus.cdb_rob_id[4:0]), 64'd10);
        check("all_c0_slot1", 64'(bus.cdb_rob_id[9:5]), 64'd11);
        check("all_c0_val1", 64'(bus.cdb_rd_value[63:32]), 64'hA000_0001);
        check("all_c0_rr", 64'(dut.rr_ptr), 64'd2);
        check("all_c1_ready", 64'(bus.fu_ready), 64'b1100);
        step();
        check("all_c1_slot0", 64'(bus.cdb_rob_id[4:0]), 64'd12);
        check("all_c1_slot1", 64'(bus.cdb_rob_id[9:5]), 64'd13);
        check("all_c1_phy1", 64'(bus.cdb_rd_phy[11:6]), 64'd23);
        check("all_c1_rr", 64'(dut.rr_ptr), 64'd0);
        check("all_c2_ready", 64'(bus.fu_ready), 64'b0011);
        step();
        check("all_c2_slot0", 64'(bus.cdb_rob_id[4:0]), 64'd10);
        check("all_c2_slot1", 64'(bus.cdb_rob_id[9:5]), 64'd11);
        check("all_c2_rr", 64'(dut.rr_ptr), 64'd2);

        // Move pointer to 3, then wrap-around with 4'b1001
        bus.fu_valid = 4'b0100;
        step();
        check("pre_wrap_rr", 64'(dut.rr_ptr), 64'd3);
        bus.fu_valid = 4'b1001;
        #1;
        check("wrap_ready", 64'(bus.fu_ready), 64'b1001);
        step();
        check("wrap_valid", 64'(bus.cdb_valid), 64'b11);
        check("wrap_slot0", 64'(bus.cdb_rob_id[4:0]), 64'd13);
        check("wrap_slot1", 64'(bus.cdb_rob_id[9:5]), 64'd10);
        check("wrap_arch0", 64'(bus.cdb_rd_arch[4:0]), 64'd7);
        check("wrap_rr", 64'(dut.rr_ptr), 64'd1);

        // Flush blocks grants; pointer held
        bus.fu_valid = 4'b1111;
        flush = 1'b1;
        #1;
        check("flush_ready", 64'(bus.fu_ready), 64'h0);
        step();
        check("flush_valid", 64'(bus.cdb_valid), 64'h0);
        check("flush_rr", 64'(dut.rr_ptr), 64'd1);
        flush = 1'b0;
        #1;
        check("post_flush_ready", 64'(bus.fu_ready), 64'b0110);
        step();
        check("post_flush_slot0", 64'(bus.cdb_rob_id[4:0]), 64'd11);
        check("post_flush_slot1", 64'(bus.cdb_rob_id[9:5]), 64'd12);
        check("post_flush_rr", 64'(dut.rr_ptr), 64'd3);

        // Reset mid-operation: grant FU0,FU1 then assert rst while broadcast is live
        bus.fu_valid = 4'b0011;
        step();
        check("mid_grant_valid", 64'(bus.cdb_valid), 64'b11);
        check("mid_grant_rr", 64'(dut.rr_ptr), 64'd2);
        bus.fu_valid = 4'b1111;
        rst = 1'b1;
        #1;
        check("mid_rst_ready", 64'(bus.fu_ready), 64'h0);
        step();
        check("mid_rst_valid", 64'(bus.cdb_valid), 64'h0);
        check("mid_rst_rr", 64'(dut.rr_ptr), 64'd0);
        check("mid_rst_payload", 64'(bus.cdb_rd_value), 64'h0);
        rst = 1'b0;

        // FU2 contends with FU0/FU1 for 3 cycles from rr_ptr=0
        bus.fu_valid = 4'b0111;
        #1;
        check("cont_c0_ready", 64'(bus.fu_ready), 64'b0011);
        step();
        check("cont_c1_ready", 64'(bus.fu_ready), 64'b0101);
        step();
        check("cont_c1_slot0", 64'(bus.cdb_rob_id[4:0]), 64'd12);
        check("cont_c1_slot1", 64'(bus.cdb_rob_id[9:5]), 64'd10);
        check("cont_c2_ready", 64'(bus.fu_ready), 64'b0110);
        step();
        bus.fu_valid = 4'b0000;
        check("cont_rr", 64'(dut.rr_ptr), 64'd3);
`ifdef CDB_ARB_STATS_EN
        check("stat_grant2", 64'(stat_grant_cnt[95:64]), 64'd2);
        check("stat_stall2", 64'(stat_stall_cnt[95:64]), 64'd1);
        check("stat_sum2", 64'(stat_grant_cnt[95:64] + stat_stall_cnt[95:64]), 64'd3);
        check("stat_grant0", 64'(stat_grant_cnt[31:0]), 64'd2);
        check("stat_stall1", 64'(stat_stall_cnt[63:32]), 64'd1);
        check("stat_grant3", 64'(stat_grant_cnt[127:96]), 64'd0);
`endif
        step();
        check("final_idle_valid", 64'(bus.cdb_valid), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Arbitrates NUM_FU functional-unit writeback requests onto CDB_WIDTH common-data-bus broadcast slots.
- Sits between the FU result stages (int_rs ALU, mul/div, load) and the cdb/prf/ROB consumers.
- Grants use a rotating round-robin priority, so no FU starves.
- Broadcasts are registered, giving one cycle of latency from grant to CDB.

Parameters:
- NUM_FU, 4, number of requesting functional units (2..8).
- CDB_WIDTH, 2, number of broadcast slots per cycle (1..NUM_FU).
- ROB_ID_W, 5, rob_id width.
- PRF_IDX_W, 6, physical register index width.
- ARCH_IDX_W, 5, architectural register index width.
- DATA_W, 32, result data width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  pipeline flush (branch mispredict/exception).
- fu_valid  in  NUM_FU  FU i holds a result.
- fu_ready  out  NUM_FU  FU i granted this cycle; the result is consumed.
- fu_rob_id  in  NUM_FU*ROB_ID_W  per-FU rob_id, FU i in slice i.
- fu_rd_phy  in  NUM_FU*PRF_IDX_W  per-FU destination physical register.
- fu_rd_arch  in  NUM_FU*ARCH_IDX_W  per-FU destination architectural register.
- fu_rd_value  in  NUM_FU*DATA_W  per-FU result value.
- cdb_valid  out  CDB_WIDTH  slot k broadcasting.
- cdb_rob_id  out  CDB_WIDTH*ROB_ID_W  slot k rob_id.
- cdb_rd_phy  out  CDB_WIDTH*PRF_IDX_W  slot k rd_phy.
- cdb_rd_arch  out  CDB_WIDTH*ARCH_IDX_W  slot k rd_arch.
- cdb_rd_value  out  CDB_WIDTH*DATA_W  slot k result value.

Behaviour:
- Reset:
  - cdb_valid=0.
  - cdb payload registers=0.
  - rr_ptr=0.
  - fu_ready=0 while rst is high.
- Handshake:
  - A transfer occurs when fu_valid[i] && fu_ready[i] in the same cycle.
  - fu_ready is combinational from fu_valid, rr_ptr and flush.
  - An FU must not make fu_valid depend on fu_ready.
  - An FU must hold its valid and payload stable until granted.
- Grant selection:
  - Scan FU indices rr_ptr, rr_ptr+1, ... modulo NUM_FU.
  - The first CDB_WIDTH FUs with fu_valid=1 are granted.
  - The j-th granted FU in scan order drives slot j.
  - Unused slots are invalid.
  - At most one slot per FU per cycle.
- Output register:
  - On posedge, cdb_valid[k] is loaded with "slot k granted".
  - The slot k payload is loaded from the granted FU.
  - Slots with cdb_valid[k]=0 hold their payload (don't-care to consumers).
  - Latency is one cycle: a result granted in cycle N is broadcast in cycle N+1.
  - Each cycle is independent; there is no backpressure from the CDB.
- Round-robin pointer:
  - If at least one grant occurs, rr_ptr <= (index of last-granted FU + 1) mod NUM_FU.
  - Otherwise rr_ptr is unchanged.
  - Wrap-around: the last granted FU at index NUM_FU-1 gives rr_ptr=0.
- Fairness: any FU continuously valid is granted within ceil(NUM_FU/CDB_WIDTH) cycles.
- Flush:
  - While flush=1: fu_ready=0 and no grants.
  - Next cycle: cdb_valid=0 and rr_ptr unchanged.
  - FUs are responsible for dropping their own squashed results.
- Reset mid-operation: a registered broadcast in flight is discarded; cdb_valid=0 on the cycle after rst.
- All requests valid with NUM_FU ≤ CDB_WIDTH: all FUs are granted every cycle.
- No requests: cdb_valid=0 next cycle.

Optional Feature:
CDB_ARB_STATS_EN:
- When defined, adds output ports stat_grant_cnt (NUM_FU*32) and stat_stall_cnt (NUM_FU*32).
- Per-FU 32-bit counters increment on grant, and on fu_valid && !fu_ready, respectively.
- Counters saturate at 0xFFFFFFFF, clear on rst, and are not cleared by flush.
- When undefined, neither the ports nor the counters exist, and the logic is otherwise identical.

Test Plan:
- Single request:
  - Stimulus: after reset, fu_valid=4'b0001, rob_id=3, rd_phy=6'd1, rd_arch=5'd1, value=32'h3.
  - Response: fu_ready=4'b0001 same cycle.
  - Next cycle: cdb_valid=2'b01, slot0 = {3, 1, 1, 32'h3}, rr_ptr=1.
- All four FUs valid continuously, rr_ptr=0:
  - Cycle 0 grants FU0 (slot0) and FU1 (slot1).
  - Cycle 1 grants FU2 and FU3.
  - Cycle 2 grants FU0 and FU1 again.
  - The CDB shows the matching payloads one cycle later each time.
- Wrap-around with rr_ptr=3 and fu_valid=4'b1001:
  - FU3 gets slot0 and FU0 gets slot1.
  - rr_ptr becomes 1.
- Flush with fu_valid=4'b1111 and flush=1:
  - fu_ready=0.
  - Next cycle cdb_valid=0 and rr_ptr unchanged.
  - After flush drops, grants resume from the same rr_ptr.
- Reset mid-operation:
  - Stimulus: rst asserted the cycle after a grant.
  - Response: cdb_valid=0 the following cycle, rr_ptr=0.
- CDB_ARB_STATS_EN with FU2 continuously valid against FU0/FU1 for 3 cycles:
  - stat_grant_cnt[2] counts exactly FU2's grants.
  - stat_stall_cnt[2] counts FU2's non-granted valid cycles.
  - The two counters for FU2 sum to 3.
